// File: rtl/feeder_pkg.sv
// Shared defaults and FSM encoding for the bin-count spectrum feeder.
package feeder_pkg;

    localparam int DEF_NUM_BINS    = 1024;
    localparam int DEF_BIN_W       = 20;
    localparam int DEF_LABEL_W     = 5;
    localparam int DEF_TIMEOUT_CYC = 65535;
    localparam int DEF_ADDR_W      = $clog2(DEF_NUM_BINS);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_START       = 2'd1,
        ST_STREAM      = 2'd2,
        ST_WAIT_RESULT = 2'd3
    } feeder_state_e;

endpackage

// File: rtl/bin_ping_pong_buffer.sv
// Two-bank spectrum store: in-order write side, registered read port,
// per-bank full flags released by stream_done.
module bin_ping_pong_buffer
    import feeder_pkg::*;
#(
    parameter  int NUM_BINS = DEF_NUM_BINS,
    parameter  int BIN_W    = DEF_BIN_W,
    localparam int ADDR_W   = $clog2(NUM_BINS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [BIN_W-1:0]  wr_data,
    output logic              wr_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [BIN_W-1:0]  rd_data,
    output logic              rd_full,
    input  logic              stream_done
);

    logic [BIN_W-1:0]  mem_r [0:2*NUM_BINS-1];
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [1:0]        full_r;
    logic [1:0]        full_s;
    logic              wr_bank_r;
    logic              rd_bank_r;
    logic              wr_bank_s;
    logic              rd_bank_s;
    logic              wr_ready_r;
    logic              accept_s;
    logic              last_s;
    logic [BIN_W-1:0]  rd_data_r;

    // Next bank/flag state; the two banks are never set and cleared together.
    always_comb begin
        accept_s          = wr_en && wr_ready_r;
        last_s            = accept_s && (wr_ptr_r == ADDR_W'(NUM_BINS - 1));
        full_s            = full_r;
        full_s[wr_bank_r] = full_r[wr_bank_r] | last_s;
        full_s[rd_bank_r] = full_s[rd_bank_r] & ~stream_done;
        wr_bank_s         = wr_bank_r ^ last_s;
        rd_bank_s         = rd_bank_r ^ stream_done;
    end

    // Control registers and the zero-when-idle read register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {ADDR_W{1'b0}};
            full_r     <= 2'b00;
            wr_bank_r  <= 1'b0;
            rd_bank_r  <= 1'b0;
            wr_ready_r <= 1'b1;
            rd_data_r  <= {BIN_W{1'b0}};
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            full_r     <= full_s;
            wr_bank_r  <= wr_bank_s;
            rd_bank_r  <= rd_bank_s;
            wr_ready_r <= ~full_s[wr_bank_s];
            if (rd_en) begin
                rd_data_r <= mem_r[{rd_bank_r, rd_addr}];
            end else begin
                rd_data_r <= {BIN_W{1'b0}};
            end
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[{wr_bank_r, wr_ptr_r}] <= wr_data;
        end
    end

    assign wr_ready = wr_ready_r;
    assign rd_data  = rd_data_r;
    assign rd_full  = full_r[rd_bank_r];

endmodule

// File: rtl/bin_cnt_spectrum_feeder.sv
// Streams buffered spectra to the bin-ratio ensemble and returns its verdict
// (or a timeout) to the host.
module bin_cnt_spectrum_feeder
    import feeder_pkg::*;
#(
    parameter int NUM_BINS    = DEF_NUM_BINS,
    parameter int BIN_W       = DEF_BIN_W,
    parameter int LABEL_W     = DEF_LABEL_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_valid,
    input  logic [BIN_W-1:0]   load_data,
    output logic               load_ready,
    input  logic               request_over_ensemble,
    input  logic               infer_ready_ensemble,
    input  logic [LABEL_W-1:0] final_winner_over_ensemble,
    output logic               trans_start,
    output logic [BIN_W-1:0]   bin_cnt,
    output logic               result_valid,
    output logic [LABEL_W-1:0] result_label,
    output logic               result_timeout,
    output logic               busy
);

    localparam int ADDR_W = $clog2(NUM_BINS);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

    feeder_state_e      state_r;
    feeder_state_e      state_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [WAIT_W-1:0]  wait_r;
    logic               rd_en_s;
    logic [ADDR_W-1:0]  rd_addr_s;
    logic               rd_full_s;
    logic               stream_done_s;
    logic               verdict_s;
    logic               timeout_s;
    logic               trans_start_r;
    logic               busy_r;
    logic               result_valid_r;
    logic               result_timeout_r;
    logic [LABEL_W-1:0] result_label_r;

    bin_ping_pong_buffer #(
        .NUM_BINS (NUM_BINS),
        .BIN_W    (BIN_W)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (load_valid),
        .wr_data     (load_data),
        .wr_ready    (load_ready),
        .rd_en       (rd_en_s),
        .rd_addr     (rd_addr_s),
        .rd_data     (bin_cnt),
        .rd_full     (rd_full_s),
        .stream_done (stream_done_s)
    );

    // Next-state and read-issue logic; cnt_r reaching NUM_BINS marks the last bin on bin_cnt.
    always_comb begin
        state_next_s  = state_r;
        rd_en_s       = 1'b0;
        rd_addr_s     = {ADDR_W{1'b0}};
        stream_done_s = 1'b0;
        verdict_s     = 1'b0;
        timeout_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rd_full_s && request_over_ensemble) begin
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                rd_en_s      = 1'b1;
                state_next_s = ST_STREAM;
            end
            ST_STREAM: begin
                if (cnt_r[ADDR_W]) begin
                    stream_done_s = 1'b1;
                    state_next_s  = ST_WAIT_RESULT;
                end else begin
                    rd_en_s   = 1'b1;
                    rd_addr_s = cnt_r[ADDR_W-1:0];
                end
            end
            ST_WAIT_RESULT: begin
                if (infer_ready_ensemble) begin
                    verdict_s    = 1'b1;
                    state_next_s = ST_IDLE;
                end else if (wait_r == WAIT_W'(TIMEOUT_CYC - 1)) begin
                    timeout_s    = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT_RESULT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r          <= ST_IDLE;
            cnt_r            <= {CNT_W{1'b0}};
            wait_r           <= {WAIT_W{1'b0}};
            trans_start_r    <= 1'b0;
            busy_r           <= 1'b0;
            result_valid_r   <= 1'b0;
            result_timeout_r <= 1'b0;
            result_label_r   <= {LABEL_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (state_r == ST_START) begin
                cnt_r <= CNT_W'(1);
            end else if (state_r == ST_STREAM) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= {CNT_W{1'b0}};
            end
            if (state_r == ST_WAIT_RESULT) begin
                wait_r <= wait_r + WAIT_W'(1);
            end else begin
                wait_r <= {WAIT_W{1'b0}};
            end
            trans_start_r    <= (state_next_s == ST_START);
            busy_r           <= (state_next_s != ST_IDLE);
            result_valid_r   <= verdict_s | timeout_s;
            result_timeout_r <= timeout_s;
            if (verdict_s) begin
                result_label_r <= final_winner_over_ensemble;
            end else begin
                result_label_r <= result_label_r;
            end
        end
    end

    assign trans_start    = trans_start_r;
    assign busy           = busy_r;
    assign result_valid   = result_valid_r;
    assign result_timeout = result_timeout_r;
    assign result_label   = result_label_r;

endmodule

// File: tb/tb_bin_cnt_spectrum_feeder.sv
// Directed bench for bin_cnt_spectrum_feeder: table of single-spectrum
// transactions plus hand-written gating, ping-pong and reset sequences.
module tb_bin_cnt_spectrum_feeder;

    localparam int N  = 1024;
    localparam int BW = 20;
    localparam int LW = 5;
    localparam int TO = 100;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_valid;
    logic [BW-1:0] load_data;
    logic          load_ready;
    logic          request_over_ensemble;
    logic          infer_ready_ensemble;
    logic [LW-1:0] final_winner_over_ensemble;
    logic          trans_start;
    logic [BW-1:0] bin_cnt;
    logic          result_valid;
    logic [LW-1:0] result_label;
    logic          result_timeout;
    logic          busy;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        int            base;
        logic [LW-1:0] winner;
        int            mode;      // 0 verdict, 1 timeout, 2 verdict on timeout cycle
        logic [LW-1:0] exp_label;
        logic          exp_timeout;
    } vec_t;

    vec_t vecs [4];

    bin_cnt_spectrum_feeder #(
        .NUM_BINS    (N),
        .BIN_W       (BW),
        .LABEL_W     (LW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk                        (clk),
        .rst                        (rst),
        .load_valid                 (load_valid),
        .load_data                  (load_data),
        .load_ready                 (load_ready),
        .request_over_ensemble      (request_over_ensemble),
        .infer_ready_ensemble       (infer_ready_ensemble),
        .final_winner_over_ensemble (final_winner_over_ensemble),
        .trans_start                (trans_start),
        .bin_cnt                    (bin_cnt),
        .result_valid               (result_valid),
        .result_label               (result_label),
        .result_timeout             (result_timeout),
        .busy                       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_state();
        check("rst_trans_start", 32'(trans_start), 32'd0);
        check("rst_bin_cnt", 32'(bin_cnt), 32'd0);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_result_label", 32'(result_label), 32'd0);
        check("rst_result_timeout", 32'(result_timeout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_load_ready", 32'(load_ready), 32'd1);
    endtask

    task automatic load_spectrum(input int base);
        int   k   = 0;
        int   cyc = 0;
        logic acc;
        while (k < N && cyc < 4 * N) begin
            load_valid = 1'b1;
            load_data  = BW'(base + k);
            acc        = load_ready;
            tick();
            if (acc) k++;
            cyc++;
        end
        load_valid = 1'b0;
        check("load_complete", 32'(k), 32'(N));
    endtask

    task automatic expect_stream(input int base);
        int cyc = 0;
        int bad = 0;
        while (trans_start !== 1'b1 && cyc < 5000) begin
            tick();
            cyc++;
        end
        check("trans_start_seen", 32'(trans_start), 32'd1);
        check("busy_at_start", 32'(busy), 32'd1);
        for (int k = 0; k < N; k++) begin
            tick();
            if (bin_cnt !== BW'(base + k) || trans_start !== 1'b0) bad++;
        end
        check("stream_bad_bins", 32'(bad), 32'd0);
        tick();
        check("bin_cnt_after_stream", 32'(bin_cnt), 32'd0);
    endtask

    task automatic give_verdict(input logic [LW-1:0] w);
        infer_ready_ensemble       = 1'b1;
        final_winner_over_ensemble = w;
        tick();
        infer_ready_ensemble = 1'b0;
        check("verdict_valid", 32'(result_valid), 32'd1);
        check("verdict_label", 32'(result_label), 32'(w));
        check("verdict_timeout", 32'(result_timeout), 32'd0);
        check("verdict_idle", 32'(busy), 32'd0);
        tick();
        check("verdict_pulse_end", 32'(result_valid), 32'd0);
    endtask

    initial begin
        int seen;
        vecs[0] = '{1,      5'd17, 0, 5'd17, 1'b0};
        vecs[1] = '{100000, 5'd31, 1, 5'd17, 1'b1};
        vecs[2] = '{300000, 5'd9,  2, 5'd9,  1'b0};
        vecs[3] = '{700000, 5'd30, 0, 5'd30, 1'b0};

        rst                        = 1'b1;
        load_valid                 = 1'b0;
        load_data                  = {BW{1'b0}};
        request_over_ensemble      = 1'b0;
        infer_ready_ensemble       = 1'b0;
        final_winner_over_ensemble = {LW{1'b0}};
        tick();
        tick();
        check_reset_state();
        rst = 1'b0;
        tick();

        // Single-spectrum transactions ending in verdict, timeout or collision.
        request_over_ensemble = 1'b1;
        for (int i = 0; i < 4; i++) begin
            load_spectrum(vecs[i].base);
            expect_stream(vecs[i].base);
            final_winner_over_ensemble = vecs[i].winner;
            if (vecs[i].mode == 0) begin
                infer_ready_ensemble = 1'b1;
                tick();
            end else begin
                seen = 0;
                for (int c = 0; c < TO - 1; c++) begin
                    tick();
                    if (result_valid) seen++;
                end
                check("no_early_result", 32'(seen), 32'd0);
                infer_ready_ensemble = (vecs[i].mode == 2);
                tick();
            end
            infer_ready_ensemble = 1'b0;
            check("tbl_result_valid", 32'(result_valid), 32'd1);
            check("tbl_result_label", 32'(result_label), 32'(vecs[i].exp_label));
            check("tbl_result_timeout", 32'(result_timeout), 32'(vecs[i].exp_timeout));
            check("tbl_idle", 32'(busy), 32'd0);
            tick();
            check("tbl_pulse_end", 32'(result_valid), 32'd0);
        end

        // Request gating: full bank held until request rises.
        request_over_ensemble = 1'b0;
        load_spectrum(2000);
        seen = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (trans_start || busy) seen++;
        end
        check("gated_no_start", 32'(seen), 32'd0);
        request_over_ensemble = 1'b1;
        tick();
        check("start_after_request", 32'(trans_start), 32'd1);
        expect_stream(2000);
        give_verdict(5'd4);

        // Ping-pong: B loads during A's stream, a third word is refused.
        load_spectrum(400000);
        fork
            expect_stream(400000);
            begin
                load_spectrum(600000);
                load_valid = 1'b1;
                load_data  = 20'd999;
                check("third_blocked_a", 32'(load_ready), 32'd0);
                tick();
                check("third_blocked_b", 32'(load_ready), 32'd0);
                load_valid = 1'b0;
            end
        join
        check("ready_after_a_done", 32'(load_ready), 32'd1);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (trans_start) seen++;
        end
        check("b_waits_for_a_result", 32'(seen), 32'd0);
        give_verdict(5'd22);
        expect_stream(600000);
        give_verdict(5'd1);

        // Reset in the middle of a stream.
        load_spectrum(800000);
        seen = 0;
        while (trans_start !== 1'b1 && seen < 5000) begin
            tick();
            seen++;
        end
        for (int c = 0; c < 301; c++) tick();
        check("bin_300_before_reset", 32'(bin_cnt), 32'd800300);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state();
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (trans_start || busy) seen++;
        end
        check("banks_empty_after_reset", 32'(seen), 32'd0);
        load_spectrum(900000);
        expect_stream(900000);
        give_verdict(5'd11);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/bin_cnt_spectrum_feeder.md
Name: bin_cnt_spectrum_feeder

Overview:
- Transmit side of the bin-count interface consumed by the trimmed 5-net bin-ratio ensemble.
- Buffers incoming spectra (NUM_BINS 20-bit bin counts) in a ping-pong store, then streams each spectrum to the ensemble one bin per cycle, framed by a trans_start pulse, once the ensemble signals it is ready.
- Waits for the ensemble verdict and returns the winning label, or a timeout flag, to the upstream host.

Parameters:
- NUM_BINS, 1024, bins per spectrum; power of two, ≥4.
- BIN_W, 20, bin count width; must match ensemble bin_cnt.
- LABEL_W, 5, width of the ensemble winner label.
- TIMEOUT_CYC, 65535, maximum cycles spent in WAIT_RESULT before aborting.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  upstream bin word valid.
- load_data  in  BIN_W  upstream bin count; bins arrive in order 0..NUM_BINS-1.
- load_ready  out  1  feeder can accept load_data.
- request_over_ensemble  in  1  ensemble idle and ready for a new spectrum.
- infer_ready_ensemble  in  1  ensemble verdict valid.
- final_winner_over_ensemble  in  LABEL_W  ensemble verdict.
- trans_start  out  1  one-cycle frame-start pulse to the ensemble.
- bin_cnt  out  BIN_W  streamed bin count.
- result_valid  out  1  one-cycle pulse: verdict or timeout available.
- result_label  out  LABEL_W  captured winner; held until the next result.
- result_timeout  out  1  qualifies result_valid; 1 = aborted, label invalid.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: all outputs 0 except load_ready=1. Both bank-full flags are cleared. wr_bank=0, rd_bank=0, FSM=IDLE. Reset mid-stream aborts immediately; a partially loaded bank is discarded.
- Load side: a word is written when load_valid && load_ready. The write pointer increments per accepted word.
  - Accepting word NUM_BINS-1 sets full[wr_bank], toggles wr_bank and wraps the pointer to 0.
  - load_ready = !full[wr_bank].
- FSM states: IDLE, START, STREAM, WAIT_RESULT.
- IDLE -> START when full[rd_bank] && request_over_ensemble. In START, trans_start=1 for exactly one cycle and the memory read of address 0 is issued.
- START -> STREAM unconditionally.
  - With trans_start high in cycle T, bin_cnt carries bin k in cycle T+1+k, for k=0..NUM_BINS-1. This is a registered read with 1-cycle latency.
  - bin_cnt = 0 in all other cycles.
- STREAM -> WAIT_RESULT after bin NUM_BINS-1 is driven. In that same cycle, full[rd_bank] is cleared and rd_bank toggles.
- WAIT_RESULT:
  - On infer_ready_ensemble=1, capture final_winner_over_ensemble into result_label, pulse result_valid with result_timeout=0, and go to IDLE.
  - The wait counter starts at 0 on entry. If it reaches TIMEOUT_CYC first, pulse result_valid with result_timeout=1, leave result_label unchanged, and go to IDLE.
  - infer_ready arriving in the same cycle as the timeout takes priority: it is reported as a verdict, not a timeout.
- infer_ready_ensemble outside WAIT_RESULT is ignored.
- request_over_ensemble is sampled only in IDLE; deassertion during STREAM does not stall the stream.
- Simultaneous events:
  - A bank fill completing in the same cycle a stream ends both apply. The full flags are independent bits, each set or cleared by its own event.
  - The write side never targets rd_bank while that bank is full or streaming.
- Back-to-back operation: the next spectrum may be loaded during STREAM/WAIT_RESULT. When both banks are full, load_ready=0 until a stream completes.
- busy = (state != IDLE).

Decomposition:
- Shared package (feeder_pkg) holds:
  - NUM_BINS, BIN_W, LABEL_W and TIMEOUT_CYC defaults;
  - derived ADDR_W = clog2(NUM_BINS);
  - the FSM state encoding (2-bit localparams).
- Natural sub-module: bin_ping_pong_buffer. It contains two NUM_BINS×BIN_W banks, the write pointer, the full flags, wr_bank/rd_bank, a registered read port and a stream_done input that frees the read bank.
- The top level holds the FSM, read address counter, wait counter and result registers.

Test Plan:
- Reset then single spectrum: load bins k=k+1 (1..1024) with request_over_ensemble=1.
  - Expect trans_start one cycle, then bin_cnt=1..1024 on 1024 consecutive cycles and bin_cnt=0 afterwards.
  - Drive infer_ready with winner 5'd17 → result_valid pulse, result_label=17, result_timeout=0.
- Request gating: a full bank with request_over_ensemble=0 for 50 cycles → no trans_start and busy=0. Raise request → trans_start on the next cycle.
- Ping-pong: load spectrum A, then load spectrum B during A's stream; attempt a third spectrum.
  - Expect load_ready=0 until A's last bin.
  - B streams only after A's result, with correct B data.
- Timeout: TIMEOUT_CYC=100, no infer_ready → result_valid with result_timeout=1 exactly 100 cycles after WAIT_RESULT entry. result_label keeps its prior value; FSM back in IDLE.
- Timeout/verdict collision: infer_ready on the timeout cycle → result_timeout=0 and label captured.
- Reset mid-stream at bin 300: all outputs at reset values next cycle, both banks empty, load_ready=1. A following full reload streams from bin 0 correctly.
